bus1_arbiter: RTL

Two-requester arbiter and transaction sequencer for the shared CPU-to-cache bus (C1/A1/D1). It grants bus ownership to one requester at a time with round-robin fairness. It tracks the C1 protocol (command and address phases, C1_RESPONSE, data beats) to find the end of each transaction, then inserts one turnaround cycle before re-arbitrating. It never drives C1/A1/D1; it only observes C1_WIRE and gates requester ownership via GNT.

---
 rtl/bus1_arbiter_if.sv | 45 ++++
 rtl/bus1_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bus1_arbiter_if.sv
// bus1_arb_if: requester-side signal bundle of the shared C1/A1/D1 bus arbiter.
//
// Signals:
//   req      [1:0]  per-requester bus request (level)
//   lock     [1:0]  per-requester lock hint (used only when locking is compiled in)
//   c1_wire  [W-1:0] monitored C1 command/response bus
//   gnt      [1:0]  one-hot grant, or 00
//   owner           index of current/last owner
//   busy            arbiter is not idle
//   timeout         one-cycle pulse on forced release
//
// Modports:
//   master - requesters / bus environment: drive req, lock, c1_wire; observe grant status
//   slave  - the arbiter: observes req, lock, c1_wire; drives grant status
interface bus1_arb_if #(
    parameter int unsigned CTR1_BUS_SIZE = 3
);
    logic [1:0]               req;
    logic [1:0]               lock;
    logic [CTR1_BUS_SIZE-1:0] c1_wire;
    logic [1:0]               gnt;
    logic                     owner;
    logic                     busy;
    logic                     timeout;

    modport master (
        output req,
        output lock,
        output c1_wire,
        input  gnt,
        input  owner,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  lock,
        input  c1_wire,
        output gnt,
        output owner,
        output busy,
        output timeout
    );
endinterface

// File: rtl/bus1_arbiter.sv
// bus1_arbiter: two-requester round-robin arbiter and transaction sequencer for the shared
// CPU-to-cache bus. It follows the C1 protocol (command, second address half, response,
// data beats) to find the end of each transaction, then holds the grant low for one
// turnaround cycle before arbitrating again. It never drives C1/A1/D1.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   bus1_arb_if.slave: req/lock/c1_wire in; gnt/owner/busy/timeout out (all registered)
//
// Parameters:
//   CTR1_BUS_SIZE   width of the C1 command bus
//   TIMEOUT_CYCLES  WAIT_RESP cycles before a forced release (>= 2)
//   C1_*            command encodings; override to match the shared commands header
//
// Optional feature: define BUS1_ARB_LOCK_EN to let a locked owner chain up to four
// consecutive transactions without re-arbitration.
module bus1_arbiter #(
    parameter int unsigned            CTR1_BUS_SIZE      = 3,
    parameter int unsigned            TIMEOUT_CYCLES     = 64,
    parameter logic [CTR1_BUS_SIZE-1:0] C1_NOP             = 'd0,
    parameter logic [CTR1_BUS_SIZE-1:0] C1_READ8           = 'd1,
    parameter logic [CTR1_BUS_SIZE-1:0] C1_READ16          = 'd2,
    parameter logic [CTR1_BUS_SIZE-1:0] C1_READ32          = 'd3,
    parameter logic [CTR1_BUS_SIZE-1:0] C1_WRITE8          = 'd4,
    parameter logic [CTR1_BUS_SIZE-1:0] C1_WRITE16         = 'd5,
    parameter logic [CTR1_BUS_SIZE-1:0] C1_WRITE32         = 'd6,
    parameter logic [CTR1_BUS_SIZE-1:0] C1_INVALIDATE_LINE = 'd7,
    // Nine codes do not fit in three bits. The response shares the invalidate code point:
    // it is only decoded in WAIT_RESP, where requesters never drive commands.
    parameter logic [CTR1_BUS_SIZE-1:0] C1_RESPONSE        = 'd7
) (
    input  logic      clk,
    input  logic      rst,
    bus1_arb_if.slave bus
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StWaitResp,
        StData,
        StRelease
    } state_e;

    state_e          state_q;
    logic [1:0]      gnt_q;
    logic            owner_q;
    logic            busy_q;
    logic            timeout_q;
    logic            ptr_q;      // last-served requester
    logic [1:0]      beats_q;    // data beats still to come
    logic [CntW-1:0] cnt_q;      // WAIT_RESP cycles without a response

`ifdef BUS1_ARB_LOCK_EN
    logic [1:0]      lock_cnt_q; // transactions already chained in the current lock
`else
    logic            unused_lock;
    assign unused_lock = ^bus.lock;
`endif

    // Command decode
    logic       cmd_valid;
    logic [1:0] cmd_beats;
    logic       is_resp;
    logic       rr_winner;

    always_comb begin
        cmd_valid = 1'b1;
        cmd_beats = 2'd0;
        if (bus.c1_wire == C1_READ8 || bus.c1_wire == C1_READ16) begin
            cmd_beats = 2'd1;
        end else if (bus.c1_wire == C1_READ32) begin
            cmd_beats = 2'd2;
        end else if (bus.c1_wire == C1_WRITE8 || bus.c1_wire == C1_WRITE16 ||
                     bus.c1_wire == C1_WRITE32 || bus.c1_wire == C1_INVALIDATE_LINE) begin
            cmd_beats = 2'd0;
        end else begin
            // NOP, or any code that is not a command
            cmd_valid = 1'b0;
        end
    end

    assign is_resp = (bus.c1_wire == C1_RESPONSE);

    // On conflict the requester that was not served last wins.
    assign rr_winner = (bus.req == 2'b11) ? ~ptr_q : bus.req[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            gnt_q      <= 2'b00;
            owner_q    <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            ptr_q      <= 1'b1;
            beats_q    <= 2'd0;
            cnt_q      <= '0;
`ifdef BUS1_ARB_LOCK_EN
            lock_cnt_q <= 2'd0;
`endif
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (|bus.req) begin
                        owner_q <= rr_winner;
                        gnt_q   <= rr_winner ? 2'b10 : 2'b01;
                        busy_q  <= 1'b1;
                        state_q <= StCmd;
                    end
                end
                StCmd: begin
                    if (cmd_valid) begin
                        beats_q <= cmd_beats;
                        state_q <= StAddr;
                    end else begin
                        gnt_q   <= 2'b00;
                        state_q <= StRelease;
                    end
                end
                StAddr: begin
                    cnt_q   <= '0;
                    state_q <= StWaitResp;
                end
                StWaitResp: begin
                    if (is_resp) begin
                        // The response edge carries the first data beat, if any.
                        if (beats_q > 2'd1) begin
                            beats_q <= beats_q - 2'd1;
                            state_q <= StData;
                        end else begin
                            gnt_q   <= 2'b00;
                            state_q <= StRelease;
                        end
                    end else if (cnt_q == CntLast) begin
                        timeout_q <= 1'b1;
                        gnt_q     <= 2'b00;
                        state_q   <= StRelease;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (beats_q <= 2'd1) begin
                        beats_q <= 2'd0;
                        gnt_q   <= 2'b00;
                        state_q <= StRelease;
                    end else begin
                        beats_q <= beats_q - 2'd1;
                    end
                end
                StRelease: begin
`ifdef BUS1_ARB_LOCK_EN
                    if (bus.lock[owner_q] && bus.req[owner_q] && lock_cnt_q < 2'd3) begin
                        // Chain another transaction; pointer untouched so priority holds.
                        lock_cnt_q <= lock_cnt_q + 2'd1;
                        gnt_q      <= owner_q ? 2'b10 : 2'b01;
                        state_q    <= StCmd;
                    end else begin
                        lock_cnt_q <= 2'd0;
                        ptr_q      <= owner_q;
                        busy_q     <= 1'b0;
                        state_q    <= StIdle;
                    end
`else
                    ptr_q   <= owner_q;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
`endif
                end
                default: begin
                    gnt_q   <= 2'b00;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;

endmodule
